// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: two-requester round-robin front end for a single-port RAM.
// After every reset it first writes Init_Value to every RAM word (INIT).
// It then serves requests (SERVE).
//
// Handshake: a requester raises req_x and holds it, together with wr_x/addr_x/wdata_x,
// until it sees ack_x high in a cycle. ack_x is combinational from req_x.
// The access is performed in the cycle ack_x is high. Dropping req_x before ack_x
// withdraws the request. A read returns rdata one cycle after its ack, flagged by rvalid_x.
module ram_port_arbiter #(
  parameter int                    Data_Width = 8,
  parameter int                    Addr_Width = 2,
  parameter logic [Data_Width-1:0] Init_Value = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_a,
  input  logic                  wr_a,
  input  logic [Addr_Width-1:0] addr_a,
  input  logic [Data_Width-1:0] wdata_a,
  output logic                  ack_a,
  output logic                  rvalid_a,
  input  logic                  req_b,
  input  logic                  wr_b,
  input  logic [Addr_Width-1:0] addr_b,
  input  logic [Data_Width-1:0] wdata_b,
  output logic                  ack_b,
  output logic                  rvalid_b,
  output logic [Data_Width-1:0] rdata,
  output logic                  init_done,
  output logic                  ram_wr_rd_ena,
  output logic [Addr_Width-1:0] ram_addr,
  output logic [Data_Width-1:0] ram_data_write,
  input  logic [Data_Width-1:0] ram_data_read
);

  typedef enum logic {
    ST_INIT  = 1'b0,
    ST_SERVE = 1'b1
  } state_t;

  localparam logic [Addr_Width-1:0] ADDR_LAST = '1;
  localparam logic [Addr_Width-1:0] ADDR_ONE  = Addr_Width'(1);

  state_t                state_q, state_d;
  logic [Addr_Width-1:0] init_addr_q;
  logic                  last_q;   // 0: A was granted last, 1: B was granted last
  logic                  gnt_a, gnt_b;

  assign rdata = ram_data_read;
  assign ack_a = gnt_a;
  assign ack_b = gnt_b;

  // Grant selection: a single requester wins, and a tie goes to the one not granted last.
  always_comb begin
    gnt_a = 1'b0;
    gnt_b = 1'b0;
    if (!rst && state_q == ST_SERVE) begin
      if (req_a && req_b) begin
        gnt_a = last_q;
        gnt_b = !last_q;
      end else begin
        gnt_a = req_a;
        gnt_b = req_b;
      end
    end
  end

  // Next state and RAM port drive; the port idles at zero when nothing is granted.
  always_comb begin
    state_d        = state_q;
    ram_wr_rd_ena  = 1'b0;
    ram_addr       = '0;
    ram_data_write = '0;
    if (!rst && state_q == ST_INIT) begin
      ram_wr_rd_ena  = 1'b1;
      ram_addr       = init_addr_q;
      ram_data_write = Init_Value;
      if (init_addr_q == ADDR_LAST) begin
        state_d = ST_SERVE;
      end
    end else if (gnt_a) begin
      ram_wr_rd_ena  = wr_a;
      ram_addr       = addr_a;
      ram_data_write = wdata_a;
    end else if (gnt_b) begin
      ram_wr_rd_ena  = wr_b;
      ram_addr       = addr_b;
      ram_data_write = wdata_b;
    end
  end

  // State, init counter, round-robin pointer and read-return flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_INIT;
      init_addr_q <= '0;
      last_q      <= 1'b1;
      init_done   <= 1'b0;
      rvalid_a    <= 1'b0;
      rvalid_b    <= 1'b0;
    end else begin
      state_q   <= state_d;
      init_done <= (state_d == ST_SERVE);
      if (state_q == ST_INIT) begin
        init_addr_q <= init_addr_q + ADDR_ONE;
      end
      if (gnt_a) begin
        last_q <= 1'b0;
      end else if (gnt_b) begin
        last_q <= 1'b1;
      end
      rvalid_a <= gnt_a && !wr_a;
      rvalid_b <= gnt_b && !wr_b;
    end
  end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb_ram_port_arbiter: drives ram_port_arbiter against a behavioural single-port RAM.
// It checks init, grants, round-robin order and read return through an expected-data queue.
module tb_ram_port_arbiter;

  localparam int         DW   = 8;
  localparam int         AW   = 2;
  localparam logic [7:0] INIT = 8'h5A;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_a = 1'b0, wr_a = 1'b0, req_b = 1'b0, wr_b = 1'b0;
  logic [AW-1:0] addr_a = '0, addr_b = '0;
  logic [DW-1:0] wdata_a = '0, wdata_b = '0;
  logic          ack_a, ack_b, rvalid_a, rvalid_b, init_done;
  logic [DW-1:0] rdata, ram_data_write, ram_data_read;
  logic          ram_wr_rd_ena;
  logic [AW-1:0] ram_addr;

  ram_port_arbiter #(.Data_Width(DW), .Addr_Width(AW), .Init_Value(INIT)) dut (
    .clk(clk), .rst(rst),
    .req_a(req_a), .wr_a(wr_a), .addr_a(addr_a), .wdata_a(wdata_a),
    .ack_a(ack_a), .rvalid_a(rvalid_a),
    .req_b(req_b), .wr_b(wr_b), .addr_b(addr_b), .wdata_b(wdata_b),
    .ack_b(ack_b), .rvalid_b(rvalid_b),
    .rdata(rdata), .init_done(init_done),
    .ram_wr_rd_ena(ram_wr_rd_ena), .ram_addr(ram_addr),
    .ram_data_write(ram_data_write), .ram_data_read(ram_data_read)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // Behavioural RAM: registered address, data out one cycle after the address.
  logic [DW-1:0] ram_mem [4];
  always @(posedge clk) begin
    if (ram_wr_rd_ena) ram_mem[ram_addr] <= ram_data_write;
    ram_data_read <= ram_mem[ram_addr];
  end

  // ---------------- scoreboard state ----------------
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] model_mem [4];
  logic          m_last;
  logic          pend_a, pend_b;
  int            n_checks = 0;
  int            n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < 4; i++) model_mem[i] = INIT;
    m_last = 1'b1;
    pend_a = 1'b0;
    pend_b = 1'b0;
    exp_q.delete();
  endtask

  // Assert reset for two edges and check reset outputs. Release rst just after the
  // negedge, so the caller sits in the first cycle after release.
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_ack_a", ack_a, 0);
    check("rst_ack_b", ack_b, 0);
    check("rst_ena", ram_wr_rd_ena, 0);
    @(negedge clk);
    #1;
    check("rst_init_done", init_done, 0);
    check("rst_rvalid_a", rvalid_a, 0);
    check("rst_rvalid_b", rvalid_b, 0);
    rst = 1'b0;
    #1;
    clear_model();
  endtask

  // Four INIT cycles: writes of INIT to 0..3 and no acks, whatever the requests are.
  task automatic run_init();
    for (int i = 0; i < 4; i++) begin
      if (i > 0) begin
        @(negedge clk);
        #1;
      end
      check("init_ena", ram_wr_rd_ena, 1);
      check("init_addr", ram_addr, i);
      check("init_data", ram_data_write, INIT);
      check("init_ack_a", ack_a, 0);
      check("init_ack_b", ack_b, 0);
      check("init_done_low", init_done, 0);
      check("init_rvalid_a", rvalid_a, 0);
    end
  endtask

  // One SERVE cycle. Drive the requests and check the read return from the previous cycle.
  // Predict the grant from the round-robin model and check the acks and the RAM port.
  task automatic cycle(input logic ra, input logic wa, input logic [AW-1:0] aa, input logic [DW-1:0] da,
                       input logic rb, input logic wb, input logic [AW-1:0] ab, input logic [DW-1:0] db);
    logic ea, eb;
    logic [DW-1:0] e;
    @(negedge clk);
    req_a = ra; wr_a = wa; addr_a = aa; wdata_a = da;
    req_b = rb; wr_b = wb; addr_b = ab; wdata_b = db;
    #1;
    check("init_done", init_done, 1);
    check("rvalid_a", rvalid_a, pend_a);
    check("rvalid_b", rvalid_b, pend_b);
    if (pend_a || pend_b) begin
      if (exp_q.size() == 0) check("exp_q_empty", 1, 0);
      else begin
        e = exp_q.pop_front();
        check("rdata", rdata, e);
      end
    end
    ea = ra && (!rb || m_last);
    eb = rb && !ea;
    check("ack_a", ack_a, ea);
    check("ack_b", ack_b, eb);
    check("ram_ena", ram_wr_rd_ena, ea ? wa : (eb ? wb : 1'b0));
    check("ram_addr", ram_addr, ea ? aa : (eb ? ab : '0));
    check("ram_wdata", ram_data_write, ea ? da : (eb ? db : '0));
    pend_a = ea && !wa;
    pend_b = eb && !wb;
    if (ea) begin
      if (wa) model_mem[aa] = da; else exp_q.push_back(model_mem[aa]);
      m_last = 1'b0;
    end else if (eb) begin
      if (wb) model_mem[ab] = db; else exp_q.push_back(model_mem[ab]);
      m_last = 1'b1;
    end
  endtask

  task automatic idle();
    cycle(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    // Reset and init, with A's read request held from before reset release.
    req_a = 1'b1; wr_a = 1'b0; addr_a = 2'd2;
    do_reset();
    run_init();
    cycle(1, 0, 2, 0, 0, 0, 0, 0);   // first SERVE cycle: A acked at once
    idle();                          // rvalid_a with 5A

    // Write then read across requesters.
    cycle(1, 1, 1, 8'hC3, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 1, 0, 1, 0);
    idle();
    check("rdata_c3_seen", model_mem[1], 8'hC3);

    // Contention right after a fresh reset: A, B, A, B, A, B.
    do_reset();
    run_init();
    for (int i = 0; i < 6; i++) begin
      cycle(1, 0, 2'(i), 0, 1, 0, 2'(i + 1), 0);
      check("tie_order", ack_a, (i % 2) == 0);
    end
    idle();

    // Back-to-back reads after writes of 10..13.
    for (int i = 0; i < 4; i++) cycle(1, 1, 2'(i), 8'(8'h10 + i), 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) cycle(1, 0, 2'(i), 0, 0, 0, 0, 0);
    idle();

    // Randomised traffic against the round-robin model.
    for (int i = 0; i < 40; i++) begin
      cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)));
    end
    idle();
    idle();

    // Reset in the cycle of an A read ack: no rvalid follows, and INIT rewrites all words.
    @(negedge clk);
    req_a = 1'b1; wr_a = 1'b0; addr_a = 2'd3; req_b = 1'b0;
    #1;
    check("mr_ack_a", ack_a, 1);
    rst = 1'b1;
    #1;
    check("mr_ack_gated", ack_a, 0);
    check("mr_ena_gated", ram_wr_rd_ena, 0);
    @(negedge clk);
    #1;
    check("mr_rvalid_a", rvalid_a, 0);
    check("mr_init_done", init_done, 0);
    req_a = 1'b0;
    rst = 1'b0;
    #1;
    clear_model();
    run_init();
    for (int i = 0; i < 4; i++) cycle(0, 0, 0, 0, 1, 0, 2'(i), 0);
    idle();
    for (int i = 0; i < 4; i++) check("mr_ram_rewritten", ram_mem[i], INIT);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/ram_port_arbiter.md
# ram_port_arbiter

Round-robin arbiter and initialisation sequencer in front of one single-port RAM (registered address, one write-or-read per clock). Two requesters, A and B, share the RAM port through a req/ack handshake. Read data is returned one cycle after the granted access, qualified by a per-requester valid. After every reset, the block first writes `Init_Value` to every RAM word. Only then does it serve requesters, so downstream logic never depends on a memory-init file.

## Interface
- `Data_Width`, 8, width of RAM words and data ports
- `Addr_Width`, 2, RAM address width; depth = 2**Addr_Width
- `Init_Value`, 0, word written to every address during initialisation

Ports, clock and reset first:
- `clk` in 1: single clock; all registers on rising edge
- `rst` in 1: reset, synchronous and active-high
- `req_a` in 1: requester A access request; held until `ack_a`
- `wr_a` in 1: A access type; 1 = write, 0 = read
- `addr_a` in Addr_Width: A address
- `wdata_a` in Data_Width: A write data
- `ack_a` out 1: A access performed this cycle
- `rvalid_a` out 1: `rdata` holds A's read result this cycle
- `req_b`, `wr_b`, `addr_b`, `wdata_b`, `ack_b`, `rvalid_b`: same as A, for requester B
- `rdata` out Data_Width: read data, direct copy of `ram_data_read`
- `init_done` out 1: initialisation finished; requests now served
- `ram_wr_rd_ena` out 1: to RAM write enable
- `ram_addr` out Addr_Width: to RAM address
- `ram_data_write` out Data_Width: to RAM write data
- `ram_data_read` in Data_Width: from RAM read data; valid the cycle after the address is presented

## Operation
- **States.**
  - INIT: entered on `rst`.
  - SERVE: entered after the last INIT write.
- **INIT.**
  - Counter `init_addr` starts at 0. Each cycle: `ram_wr_rd_ena`=1, `ram_addr`=`init_addr`, `ram_data_write`=`Init_Value`.
  - `init_addr` increments each cycle. When the cycle with `init_addr` = 2**Addr_Width-1 completes, the state moves to SERVE.
  - Acks are never given in INIT. Requests stay pending and are not lost.
- **SERVE, grant selection.** Selection is combinational from the current requests and the round-robin pointer `last`.
  - Only one of `req_a`/`req_b` high: grant it.
  - Both high: grant the requester that is not `last`.
  - Neither high: `ram_wr_rd_ena`=0 and no ack.
- **SERVE, granted access.**
  - `ack_x`=1 for the winner.
  - `ram_addr`=`addr_x`, `ram_data_write`=`wdata_x`, `ram_wr_rd_ena`=`wr_x`.
  - `last` ← winner at the clock edge.
- **Read return.** A granted read sets registered `rvalid_x`=1 in the next cycle, while `rdata` = word at that address. A granted write produces no `rvalid`.
- **Idle outputs.** When no grant is active, `ram_addr` and `ram_data_write` hold 0.
- **Throughput.** At most one access per cycle. Back-to-back grants to the same or alternating requesters are allowed every cycle.
- **Hazards.** Write to X in cycle t followed by a read of X in cycle t+1 returns the new data in cycle t+2. Other hazard checks are not required.

## Timing
- **Reset values.** While `rst`=1 and in the first cycle after release:
  - State = INIT, `init_addr`=0, `last`=B (so A wins the first tie).
  - `init_done`=0, `rvalid_a`=`rvalid_b`=0.
  - `ack_a`=`ack_b`=0 and `ram_wr_rd_ena`=0 while `rst`=1.
- **INIT length.** Exactly 2**Addr_Width cycles of writes after `rst` falls.
- **`init_done`.** Registered. Rises in the cycle SERVE is entered and stays 1 until the next `rst`.
- **Ack latency.** A request present in a SERVE cycle with no contention is acked in that same cycle, so ack is combinational from `req`. A loser of a tie is acked in the following cycle if it keeps `req` high.
- **Read latency.** `rvalid` and `rdata` are valid exactly 1 cycle after the `ack` of a read.
- **Fairness.** With both requests held continuously, grants alternate A, B, A, B… No requester waits more than 1 cycle.
- **Reset mid-operation.** `rst` at any point:
  - Aborts SERVE or INIT.
  - Clears a pending `rvalid` (no `rvalid` in the cycle after `rst`).
  - Restarts INIT from address 0.
- **`req` deasserted before ack.** The request is withdrawn and no access occurs.

## Test plan
- **Reset and init** (Data_Width=8, Addr_Width=2, Init_Value=8'h5A). Release `rst`.
  - Required: 4 cycles with `ram_wr_rd_ena`=1 at addresses 0,1,2,3 and data 5A.
  - Required: `init_done`=1 in cycle 5.
  - Required: then a read by A of address 2 gives `rvalid_a`=1 and `rdata`=5A one cycle after `ack_a`.
- **Requests during INIT.** Hold `req_a` from cycle 0.
  - Required: no `ack_a` until `init_done`=1.
  - Required: `ack_a` in the first SERVE cycle.
- **Write then read.** A writes 8'hC3 to address 1, B then reads address 1.
  - Required: `ack_b` one cycle after `ack_a`.
  - Required: `rvalid_b`=1 with `rdata`=C3 the next cycle; `rvalid_a` stays 0 throughout.
- **Contention.** `req_a` and `req_b` both held for 6 cycles after init.
  - Required: acks exactly A,B,A,B,A,B.
  - Required: a tie right after reset goes to A.
- **Back-to-back reads.** A reads addresses 0,1,2,3 on consecutive cycles, with prior writes 10,11,12,13.
  - Required: `rvalid_a` high 4 consecutive cycles with `rdata` = 10,11,12,13.
- **Mid-operation reset.** Assert `rst` in the cycle of an A read ack.
  - Required: no `rvalid_a` follows.
  - Required: INIT re-runs and rewrites all 4 words to `Init_Value`.
